// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   DEF_WIDTH : default operand width
//   OP_*      : op_sel encodings
//   state_e   : sequencer states
package hilo_muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute-stage interface of the multiply/divide unit.
//   master : pipeline side (request, operands, cancel, MTHI/MTLO)
//   slave  : unit side (busy/stall, done pulse, HI/LO registers)
interface hilo_muldiv_if #(
  parameter int WIDTH = hilo_muldiv_pkg::DEF_WIDTH
);
  logic             start;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_sel, src_a, src_b, cancel, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_sel, src_a, src_b, cancel, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_sign_fix.sv
// Conditional two's-complement negate.
//   neg  : 1 = output -din, 0 = output din
//   din  : W-bit value
//   dout : W-bit result
module hilo_muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = neg ? (~din + 1'b1) : din;
endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
//   clk, resetn : system clock, async active-low reset
//   bus (slave) : start/op_sel/src_a/src_b request, cancel flush,
//                 hi_we/lo_we/wdata MTHI/MTLO, busy stall, done pulse, hi/lo
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | WIDTH shift-add or restoring-divide iterations
// FIX   | sign fix-up, HI/LO write, done pulse
module hilo_muldiv import hilo_muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         resetn,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_e             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic             is_signed, sgn_a, sgn_b, b_zero, req_div;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_signed = (bus.op_sel == OP_MULT) || (bus.op_sel == OP_DIV);
  assign sgn_a     = is_signed & bus.src_a[WIDTH-1];
  assign sgn_b     = is_signed & bus.src_b[WIDTH-1];
  assign b_zero    = (bus.src_b == '0);
  assign req_div   = bus.op_sel[1];

  hilo_muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.neg(sgn_a), .din(bus.src_a), .dout(mag_a));
  hilo_muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.neg(sgn_b), .din(bus.src_b), .dout(mag_b));

  // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // Divide: acc = {remainder, quotient}; borrow in bit WIDTH means restore.
  logic [WIDTH:0] div_shl, div_diff;
  assign div_shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_shl - {1'b0, opnd};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  hilo_muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.neg(neg_res), .din(acc), .dout(prod_fix));
  hilo_muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (.neg(neg_res), .din(acc[WIDTH-1:0]), .dout(quo_fix));
  hilo_muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.neg(neg_rem), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem_fix));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      acc     <= '0;
      opnd    <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start && !bus.cancel) begin
            is_div  <= req_div;
            acc     <= {{WIDTH{1'b0}}, (req_div ? mag_a : mag_b)};
            opnd    <= req_div ? mag_b : mag_a;
            // With a zero divisor the unsigned quotient is already all ones
            // and the sign-restored remainder equals the raw dividend.
            neg_res <= (sgn_a ^ sgn_b) & ~(req_div & b_zero);
            neg_rem <= sgn_a;
            count   <= '0;
            busy_q  <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (bus.cancel) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            if (is_div) begin
              if (div_diff[WIDTH])
                acc <= {div_shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
              else
                acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            count <= count + 1'b1;
            if (count == CW'(WIDTH-1)) state <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          state  <= IDLE;
          if (!bus.cancel) begin
            done_q <= 1'b1;
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(32)) bus();

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_sel = op;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // Called #1 after the start edge. Optionally re-pulses start at cycle
  // restart_at with different operands; such a request must be ignored.
  task automatic wait_done(input int restart_at, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = (bus.busy === 1'b1);
    for (int n = 1; n <= 60; n++) begin
      if (n == restart_at) begin
        bus.start  = 1'b1;
        bus.op_sel = OP_MULTU;
        bus.src_a  = 32'h0000_0009;
        bus.src_b  = 32'h0000_0009;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic no_done_for(input int cycles, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  int lat;
  bit busy_ok;
  bit seen;
  logic [31:0] lo_before;

  initial begin
    vecs[0]  = '{"mult_neg3x5",      OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{"multu_max_sq",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{"div_neg7_2",       OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu_7_0",         OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4]  = '{"div_intmin_m1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{"mult_2p16_sq",     OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[6]  = '{"divu_100_7",       OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[7]  = '{"div_7_neg2",       OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{"div_neg7_0",       OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9]  = '{"multu_2p31x2",     OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[10] = '{"mult_intmin_sq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[11] = '{"divu_max_1",       OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

    bus.start = 1'b0; bus.op_sel = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Vector table: latency, stall window, results, single-cycle done.
    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, busy_ok);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd33);
      check({vecs[i].name, "_busy"},    64'(busy_ok), 64'd1);
      check({vecs[i].name, "_hi"},      64'(bus.hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"},      64'(bus.lo), 64'(vecs[i].exp_lo));
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, 64'(bus.done), 64'd0);
    end

    // MTHI preload, then cancel on cycle 10; MTLO while busy is ignored.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi_idle", 64'(bus.hi), 64'h1234);
    lo_before = bus.lo;
    launch(OP_MULT, 32'h0000_0003, 32'h0000_0004);
    for (int n = 1; n < 10; n++) begin
      if (n == 4) begin bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF; end
      @(posedge clk); #1;
      bus.lo_we = 1'b0;
    end
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    no_done_for(40, seen);
    check("cancel_no_done", 64'(seen), 64'd0);
    check("cancel_hi", 64'(bus.hi), 64'h1234);
    check("mtlo_busy_ignored", 64'(bus.lo), 64'(lo_before));

    // cancel and start together in IDLE: request is dropped.
    @(negedge clk);
    bus.cancel = 1'b1; bus.start = 1'b1; bus.op_sel = OP_MULTU;
    bus.src_a = 32'd5; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.cancel = 1'b0; bus.start = 1'b0;
    check("cancel_start_idle", 64'(bus.busy), 64'd0);

    // MTHI/MTLO on the start edge take effect, then FIX overwrites.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_AAAA;
    bus.start = 1'b1; bus.op_sel = OP_MULTU; bus.src_a = 32'd2; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.start = 1'b0;
    check("mt_start_hi", 64'(bus.hi), 64'hAAAA);
    check("mt_start_lo", 64'(bus.lo), 64'hAAAA);
    wait_done(0, lat, busy_ok);
    check("mt_start_latency", 64'(lat), 64'd33);
    check("mt_start_res_hi", 64'(bus.hi), 64'd0);
    check("mt_start_res_lo", 64'(bus.lo), 64'd6);

    // start re-pulsed mid-op is ignored.
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(5, lat, busy_ok);
    check("restart_latency", 64'(lat), 64'd33);
    check("restart_busy", 64'(busy_ok), 64'd1);
    check("restart_hi", 64'(bus.hi), 64'd2);
    check("restart_lo", 64'(bus.lo), 64'd14);
    no_done_for(40, seen);
    check("restart_no_second_op", 64'(seen), 64'd0);

    // Async reset mid-CALC clears everything and drops the op.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_0055;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    launch(OP_MULT, 32'h0000_0011, 32'h0000_0022);
    repeat (15) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_hi",   64'(bus.hi),   64'd0);
    check("rst_mid_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    resetn = 1'b1;
    no_done_for(40, seen);
    check("rst_mid_no_done", 64'(seen), 64'd0);
    check("rst_mid_idle", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the ALU control decoder in the execute stage. It consumes MULT/MULTU/DIV/DIVU requests and the two operands. It runs a fixed-latency shift-add or restoring-divide sequence and writes the 2·WIDTH-bit result into HI/LO. While working it raises a stall request to the pipeline; it also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request strobe, sampled only in IDLE
op_sel  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  input  WIDTH  multiplicand / dividend
src_b  input  WIDTH  multiplier / divisor
cancel  input  1  flush (exception/branch kill); aborts an in-flight op
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight; used as the pipeline stall request
done  output  1  one-cycle pulse when HI/LO are updated by an op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, resetn).
  - While resetn=0: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal counters and accumulators cleared.
  - Reset mid-operation discards the operation; no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch |src_a|, |src_b| (signed ops only; unsigned ops pass through), latch the result signs, clear the accumulator, set count=0, go to CALC.
  - busy=1 from E0 onward.
- CALC: one iteration per cycle, WIDTH iterations (edges E1..EWIDTH), then go to FIX.
  - Mul: shift-add into a 2·WIDTH accumulator.
  - Div: restoring step on a {remainder, quotient} pair.
- FIX: at edge EWIDTH+1, HI/LO are written, busy←0, done←1 for exactly one cycle, state→IDLE.
  - Mul: 2·WIDTH product, negated if operand signs differ; HI=upper half, LO=lower half.
  - Div: LO=quotient, negated if signs differ; HI=remainder, carrying the sign of the dividend.
  - Total latency: result visible WIDTH+1 cycles after the start edge (33 for WIDTH=32). Latency is fixed regardless of operand values.
- Divide by zero (src_b=0, signed or unsigned): full latency still applies; LO=all ones, HI=src_a (raw value).
- Signed overflow (DIV INT_MIN / -1): LO=INT_MIN, HI=0, which falls naturally out of the magnitude method.
- start while busy: ignored. Operands are not re-latched.
- cancel:
  - In CALC or FIX: state→IDLE at the next edge, busy=0, no done, HI/LO unchanged.
  - In IDLE: no effect. If cancel and start are both high in IDLE, cancel wins and the op is not accepted.
- MTHI/MTLO (hi_we/lo_we):
  - In IDLE: written at the edge.
  - While busy: ignored.
  - Same edge as an accepted start: the write takes effect, and the later FIX overwrites it.
  - hi_we and lo_we may both be 1; both registers are written with wdata.
- done and the FIX write never coincide with a cancel.
- hi and lo are direct register outputs. There is no internal read forwarding; MFHI/MFLO forwarding is the pipeline's concern.

Decomposition:
- Shared package: op_sel encodings (OP_MULT/OP_MULTU/OP_DIV/OP_DIVU), default WIDTH, state enum (IDLE/CALC/FIX).
- One natural sub-module: sign_fix (conditional two's-complement negate of a WIDTH or 2·WIDTH value). It is instantiated for operand absolute value and for the result fix-up. Datapath and FSM otherwise stay flat.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> after 33 cycles done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007 after the full 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- Preload HI=0x1234 via MTHI; start MULT; assert cancel on cycle 10 -> busy=0 next cycle, no done, HI still 0x1234. Separately, drive resetn low mid-CALC -> hi=lo=0, busy=0, no done. Separately, pulse start again mid-op -> ignored, first result unaffected.
